// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud-rate controller.
// Autobaud logic elsewhere is compiled in only when UART_AUTOBAUD_EN is defined.
package uart_pkg;

  localparam int OVS      = 16;
  localparam int AB_CNT_W = 16;
  localparam int DIV_W    = 11;

  typedef logic [DIV_W-1:0]    div_t;
  typedef logic [AB_CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    AB_IDLE,
    AB_WAIT_FALL,
    AB_MEASURE,
    AB_CALC,
    AB_APPLY
  } ab_state_t;

  // Start-bit length in clocks to bit period, rounded to nearest.
  function automatic cnt_t period_of(input cnt_t c);
    logic [AB_CNT_W:0] s;
    s = {1'b0, c} + (AB_CNT_W+1)'(OVS/2);
    return cnt_t'(s >> $clog2(OVS));
  endfunction

endpackage

// File: rtl/uart_baud_ctrl_if.sv
// Host-side bus of the baud controller and the link to its
// start-bit measurement unit.
interface uart_baud_if;
  import uart_pkg::*;

  logic wr;
  div_t wr_div;
  logic busy;
  logic rx;
  logic ab_start;
  div_t div;
  logic div_upd;
  logic ab_busy;
  logic ab_done;
  logic ab_err;

  modport master (
    output wr, wr_div, busy, rx, ab_start,
    input  div, div_upd, ab_busy, ab_done, ab_err
  );

  modport slave (
    input  wr, wr_div, busy, rx, ab_start,
    output div, div_upd, ab_busy, ab_done, ab_err
  );
endinterface

interface uart_meas_if;
  import uart_pkg::*;

  logic rx;
  logic clr;
  logic inc;
  logic fall;
  logic rise;
  logic cnt_max;
  cnt_t period;

  modport meas (
    input  rx, clr, inc,
    output fall, rise, cnt_max, period
  );

  modport ctrl (
    output rx, clr, inc,
    input  fall, rise, cnt_max, period
  );
endinterface

// File: rtl/uart_baud_ctrl_meas.sv
// Start-bit measurement: rx edge detector, low-time counter
// and rounded bit-period calculation.
module uart_autobaud_meas
  import uart_pkg::*;
(
  input logic i_clk,
  input logic i_rst_n,
  uart_meas_if.meas m
);

  logic r_rx_q;
  cnt_t r_cnt;
  logic w_max;

  assign w_max     = &r_cnt;
  assign m.fall    = r_rx_q & ~m.rx;
  assign m.rise    = ~r_rx_q & m.rx;
  assign m.cnt_max = w_max;
  assign m.period  = period_of(r_cnt);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_q <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_rx_q <= m.rx;
      if (m.clr)
        r_cnt <= cnt_t'(1);
      else if (m.inc && !m.rx && !w_max)
        r_cnt <= r_cnt + cnt_t'(1);
    end
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud divisor controller: host writes applied between frames,
// optional autobaud (UART_AUTOBAUD_EN) from a measured start bit.
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter div_t DEF_DIV = 11'd53
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_wr,
  input  div_t i_wr_div,
  input  logic i_busy,
  input  logic i_rx,
  input  logic i_ab_start,
  output div_t o_div,
  output logic o_div_upd,
  output logic o_ab_busy,
  output logic o_ab_done,
  output logic o_ab_err
);

  div_t r_div;
  div_t r_pend_div;
  logic r_pend;
  logic r_upd;
  logic w_wr_ok;
  logic w_ab_ld;
  logic w_host_ld;
  div_t w_ab_div;

  assign w_wr_ok   = i_wr && (i_wr_div != '0);
  assign w_host_ld = r_pend && !i_busy && !w_ab_ld;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div      <= DEF_DIV;
      r_pend_div <= '0;
      r_pend     <= 1'b0;
      r_upd      <= 1'b0;
    end else begin
      r_upd <= w_ab_ld | w_host_ld;
      if (w_ab_ld)
        r_div <= w_ab_div;
      else if (w_host_ld)
        r_div <= r_pend_div;
      if (w_wr_ok) begin
        r_pend     <= 1'b1;
        r_pend_div <= i_wr_div;
      end else if (w_host_ld) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_div     = r_div;
  assign o_div_upd = r_upd;

`ifdef UART_AUTOBAUD_EN
  ab_state_t r_state;
  ab_state_t w_state;
  div_t      r_ab_div;
  div_t      w_ab_div_nxt;
  logic      r_done;
  logic      r_err;
  logic      w_done;
  logic      w_err;
  logic      w_ld;
  cnt_t      w_per_m1;

  uart_meas_if u_mif ();

  uart_autobaud_meas u_meas (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .m       (u_mif.meas)
  );

  assign u_mif.rx  = i_rx;
  assign u_mif.clr = (r_state == AB_WAIT_FALL) && u_mif.fall;
  assign u_mif.inc = (r_state == AB_MEASURE);
  assign w_per_m1  = u_mif.period - cnt_t'(1);

  always_comb begin
    w_state      = r_state;
    w_ld         = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_ab_div_nxt = r_ab_div;
    if (i_wr && (r_state != AB_IDLE)) begin
      w_state = AB_IDLE;
    end else begin
      unique case (r_state)
        AB_IDLE:
          if (i_ab_start) w_state = AB_WAIT_FALL;
        AB_WAIT_FALL:
          if (u_mif.fall) w_state = AB_MEASURE;
        AB_MEASURE:
          if (u_mif.cnt_max) begin
            w_err   = 1'b1;
            w_state = AB_IDLE;
          end else if (u_mif.rise) begin
            w_state = AB_CALC;
          end
        AB_CALC:
          if (u_mif.period < cnt_t'(2)) begin
            w_err   = 1'b1;
            w_state = AB_IDLE;
          end else begin
            // Very slow lines would overflow the divisor; clamp.
            w_ab_div_nxt = (|w_per_m1[AB_CNT_W-1:DIV_W]) ?
                           '1 : w_per_m1[DIV_W-1:0];
            w_state      = AB_APPLY;
          end
        AB_APPLY:
          if (!i_busy) begin
            w_ld    = 1'b1;
            w_done  = 1'b1;
            w_state = AB_IDLE;
          end
        default:
          w_state = AB_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= AB_IDLE;
      r_ab_div <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ab_div <= w_ab_div_nxt;
      r_done   <= w_done;
      r_err    <= w_err;
    end
  end

  assign w_ab_ld   = w_ld;
  assign w_ab_div  = r_ab_div;
  assign o_ab_busy = (r_state != AB_IDLE);
  assign o_ab_done = r_done;
  assign o_ab_err  = r_err;
`else
  logic w_unused;

  assign w_unused  = ^{i_rx, i_ab_start};
  assign w_ab_ld   = 1'b0;
  assign w_ab_div  = DEF_DIV;
  assign o_ab_busy = 1'b0;
  assign o_ab_done = 1'b0;
  assign o_ab_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Bench for uart_baud_ctrl: expected divisor events queued by the
// stimulus, popped and compared by a monitor on every output pulse.
module tb_uart_baud_ctrl;
  import uart_pkg::*;

  typedef struct {
    logic [2:0] kind;
    div_t       div;
    int         cyc;
  } exp_t;

  localparam logic [2:0] K_UPD  = 3'b100;
  localparam logic [2:0] K_DONE = 3'b110;
  localparam logic [2:0] K_ERR  = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q[$];

  uart_baud_if bus ();

  uart_baud_ctrl dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr       (bus.wr),
    .i_wr_div   (bus.wr_div),
    .i_busy     (bus.busy),
    .i_rx       (bus.rx),
    .i_ab_start (bus.ab_start),
    .o_div      (bus.div),
    .o_div_upd  (bus.div_upd),
    .o_ab_busy  (bus.ab_busy),
    .o_ab_done  (bus.ab_done),
    .o_ab_err   (bus.ab_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [2:0] k;
    exp_t e;
    k = {bus.div_upd, bus.ab_done, bus.ab_err};
    if (k != 3'b000) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event kind=%b div=%0d cyc=%0d, required none",
                 k, bus.div, cyc);
      end else begin
        e = q.pop_front();
        if (k !== e.kind || bus.div !== e.div ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          n_bad++;
          $display("FAIL event kind=%b div=%0d cyc=%0d, required kind=%b div=%0d cyc=%0d",
                   k, bus.div, cyc, e.kind, e.div, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k,
                           input div_t d,
                           input int c);
    exp_t e;
    e.kind = k;
    e.div  = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic host_wr(input div_t v);
    bus.wr     = 1'b1;
    bus.wr_div = v;
    tick(1);
    bus.wr     = 1'b0;
  endtask

  task automatic ab_pulse();
    bus.ab_start = 1'b1;
    tick(1);
    bus.ab_start = 1'b0;
  endtask

  initial begin
    bus.wr       = 1'b0;
    bus.wr_div   = '0;
    bus.busy     = 1'b0;
    bus.rx       = 1'b1;
    bus.ab_start = 1'b0;

    tick(3);
    check("rst_div", bus.div, 53);
    check("rst_upd", bus.div_upd, 0);
    check("rst_ab_busy", bus.ab_busy, 0);
    check("rst_ab_pulses", {bus.ab_done, bus.ab_err}, 0);
    rst_n = 1'b1;
    tick(2);

    // Write held off by a busy frame, applied one cycle after it ends.
    bus.busy = 1'b1;
    host_wr(11'd100);
    tick(19);
    check("held_while_busy", bus.div, 53);
    expect_ev(K_UPD, 11'd100, cyc + 1);
    bus.busy = 1'b0;
    tick(3);
    check("div_100", bus.div, 100);

    host_wr(11'd0);
    tick(3);
    check("zero_ignored", bus.div, 100);

    expect_ev(K_UPD, 11'd55, cyc + 2);
    host_wr(11'd55);
    tick(3);
    check("div_55", bus.div, 55);

    bus.busy = 1'b1;
    host_wr(11'd10);
    host_wr(11'd20);
    tick(2);
    expect_ev(K_UPD, 11'd20, cyc + 1);
    bus.busy = 1'b0;
    tick(3);
    check("last_write_wins", bus.div, 20);

    // Back-to-back writes: registered value loads, new one stays pending.
    expect_ev(K_UPD, 11'd30, cyc + 2);
    expect_ev(K_UPD, 11'd40, cyc + 3);
    bus.wr     = 1'b1;
    bus.wr_div = 11'd30;
    tick(1);
    bus.wr_div = 11'd40;
    tick(1);
    bus.wr     = 1'b0;
    tick(3);
    check("div_40", bus.div, 40);

`ifdef UART_AUTOBAUD_EN
    ab_pulse();
    check("ab_busy_wait", bus.ab_busy, 1);
    bus.rx = 1'b0;
    tick(868);
    bus.busy = 1'b1;
    bus.rx   = 1'b1;
    tick(10);
    check("ab_apply_waits", bus.ab_busy, 1);
    expect_ev(K_DONE, 11'd53, cyc + 1);
    bus.busy = 1'b0;
    tick(3);
    check("ab_idle_after_done", bus.ab_busy, 0);
    check("ab_div_53", bus.div, 53);

    ab_pulse();
    bus.rx = 1'b0;
    tick(20);
    expect_ev(K_ERR, 11'd53, -1);
    bus.rx = 1'b1;
    tick(5);
    check("short_err_idle", bus.ab_busy, 0);
    check("short_err_div", bus.div, 53);

    ab_pulse();
    bus.rx = 1'b0;
    tick(400);
    ab_pulse();
    expect_ev(K_UPD, 11'd7, cyc + 2);
    host_wr(11'd7);
    check("abort_idle", bus.ab_busy, 0);
    bus.rx = 1'b1;
    tick(4);
    check("abort_div_7", bus.div, 7);

    ab_pulse();
    bus.rx = 1'b0;
    expect_ev(K_ERR, 11'd7, -1);
    tick(65540);
    bus.rx = 1'b1;
    tick(3);
    check("timeout_idle", bus.ab_busy, 0);
    check("timeout_div", bus.div, 7);

    ab_pulse();
    bus.rx = 1'b0;
    tick(100);
    rst_n = 1'b0;
    tick(2);
    check("mid_rst_busy", bus.ab_busy, 0);
    check("mid_rst_div", bus.div, 53);
    rst_n  = 1'b1;
    bus.rx = 1'b1;
    tick(5);
    check("post_rst_busy", bus.ab_busy, 0);
`else
    ab_pulse();
    check("ab_disabled_busy", bus.ab_busy, 0);
    bus.rx = 1'b0;
    tick(868);
    bus.rx = 1'b1;
    tick(5);
    check("ab_disabled_idle", bus.ab_busy, 0);
    check("ab_disabled_div", bus.div, 40);
`endif

    // Reset discards a pending write.
    bus.busy = 1'b1;
    host_wr(11'd77);
    rst_n = 1'b0;
    tick(2);
    rst_n    = 1'b1;
    bus.busy = 1'b0;
    tick(5);
    check("rst_clears_pend", bus.div, 53);

    tick(5);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events got=0 required=%0d", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
